// File: rtl/common_pkg.sv
// Shared types and constants for the instruction path, plus the
// register macros used for every resettable flop in this block.

`ifndef COMMON_REG_MACROS
`define COMMON_REG_MACROS
// Register with synchronous, active-high reset to rst_val.
// NOTE: sequential state is always written with <= so every flop samples
// the pre-edge value of its neighbours; = here would create ordering races.
`define FF_SR(q, d, rst_val, clk, rst) \
  always_ff @(posedge clk) begin \
    if (rst) q <= (rst_val); \
    else     q <= (d); \
  end
`endif

package common_pkg;

  // Default instruction queue depth used where the queue is instantiated.
  localparam int INST_Q_DEPTH = 8;

  // One instruction as delivered by the host.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_t;

endpackage

// File: rtl/inst_queue_ram.sv
// Instruction storage for inst_queue: DEPTH entries, one synchronous
// write port and an asynchronous read port addressed by the read pointer.

module inst_queue_ram
  import common_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  instruction_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output instruction_t             rdata
);

  instruction_t mem [DEPTH];

  // Write the pushed entry at the write pointer.
  // NOTE: the array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed and the RAM maps to plain
  // storage cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between the host and the control stage.
// Hook-up on the control side: inst_o -> control.inst_i,
// inst_valid_o -> control.inst_valid_i, inst_ready_i <- control.inst_ready_o.
// Entries become visible one cycle after they are pushed; there is no
// fall-through path and no pass-through when full.

module inst_queue
  import common_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  instruction_t           inst_i,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  input  logic                   flush_i,
  output instruction_t           inst_o,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign inst_valid_o = !empty_o;
  // Readiness looks only at occupancy and flush, never at the consumer.
  assign inst_ready_o = !full_o && !flush_i;

  assign push = inst_valid_i && inst_ready_o;
  // A pop in a flush cycle is dropped: the flush already empties the queue.
  assign pop  = inst_valid_o && inst_ready_i && !flush_i;

  // Next pointers and occupancy; power-of-two depth lets pointers wrap freely.
  // NOTE: every signal gets a value on every path through this block, which
  // keeps it purely combinational with no inferred latches.
  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Write pointer register.
  `FF_SR(wptr_q, wptr_d, '0, clk_i, rst_i)

  // Read pointer register.
  `FF_SR(rptr_q, rptr_d, '0, clk_i, rst_i)

  // Occupancy register.
  `FF_SR(count_q, count_d, '0, clk_i, rst_i)

  inst_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk_i),
    .we    (push),
    .waddr (wptr_q),
    .wdata (inst_i),
    .raddr (rptr_q),
    .rdata (inst_o)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a table of single-cycle vectors with
// hand-computed expectations, then multi-cycle sequences against a queue model.

module tb_inst_queue;
  import common_pkg::*;

  localparam int DEPTH = INST_Q_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i, inst_valid_i, flush_i, inst_ready_i;
  logic          inst_ready_o, inst_valid_o, full_o, empty_o;
  instruction_t  inst_i, inst_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  instruction_t model [$];

  always #5 clk_i = ~clk_i;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic instruction_t mk(input int n);
    return instruction_t'({8'(8'h10 + n), 24'(n * 24'h111 + 1)});
  endfunction

  // One cycle: drive at the falling edge, compare against the model, clock,
  // then advance the model with the handshake rules.
  task automatic step(input logic v, input instruction_t d, input logic rdy,
                      input logic fl, input logic rs, input string tag);
    int  sz;
    logic do_push, do_pop;
    inst_valid_i = v; inst_i = d; inst_ready_i = rdy; flush_i = fl; rst_i = rs;
    #1;
    sz = model.size();
    check({tag, " count"}, count_o, sz);
    check({tag, " valid"}, inst_valid_o, sz != 0);
    check({tag, " empty"}, empty_o, sz == 0);
    check({tag, " full"},  full_o, sz == DEPTH);
    check({tag, " ready"}, inst_ready_o, (sz < DEPTH) && !fl);
    if (sz != 0) check({tag, " head"}, inst_o, model[0]);
    do_push = v && (sz < DEPTH) && !fl;
    do_pop  = (sz != 0) && rdy && !fl;
    @(posedge clk_i);
    if (rs || fl) model.delete();
    else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
    @(negedge clk_i);
  endtask

  typedef struct {
    logic          v;
    instruction_t  d;
    logic          rdy;
    logic          fl;
    logic [CW-1:0] e_cnt;
    logic          e_val;
    logic          e_rdy;
    instruction_t  e_head;
  } vec_t;

  vec_t tbl [11];

  initial begin
    instruction_t held;
    logic         have_held;
    int           pops;

    // v, d, rdy, fl, exp count, exp valid, exp ready_o, exp head
    tbl[0]  = '{1'b1, mk(1), 1'b0, 1'b0, CW'(0), 1'b0, 1'b1, mk(0)};
    tbl[1]  = '{1'b1, mk(2), 1'b0, 1'b0, CW'(1), 1'b1, 1'b1, mk(1)};
    tbl[2]  = '{1'b0, mk(7), 1'b0, 1'b0, CW'(2), 1'b1, 1'b1, mk(1)};
    tbl[3]  = '{1'b0, mk(7), 1'b1, 1'b0, CW'(2), 1'b1, 1'b1, mk(1)};
    tbl[4]  = '{1'b1, mk(3), 1'b1, 1'b0, CW'(1), 1'b1, 1'b1, mk(2)};
    tbl[5]  = '{1'b0, mk(7), 1'b0, 1'b0, CW'(1), 1'b1, 1'b1, mk(3)};
    tbl[6]  = '{1'b1, mk(4), 1'b1, 1'b1, CW'(1), 1'b1, 1'b0, mk(3)};
    tbl[7]  = '{1'b0, mk(7), 1'b1, 1'b0, CW'(0), 1'b0, 1'b1, mk(0)};
    tbl[8]  = '{1'b1, mk(5), 1'b1, 1'b0, CW'(0), 1'b0, 1'b1, mk(0)};
    tbl[9]  = '{1'b0, mk(7), 1'b1, 1'b0, CW'(1), 1'b1, 1'b1, mk(5)};
    tbl[10] = '{1'b0, mk(7), 1'b0, 1'b0, CW'(0), 1'b0, 1'b1, mk(0)};

    rst_i = 1'b1; inst_valid_i = 1'b0; inst_i = '0; flush_i = 1'b0; inst_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst count", count_o, 0);
    check("rst valid", inst_valid_o, 0);
    check("rst empty", empty_o, 1);
    check("rst full",  full_o, 0);
    check("rst ready", inst_ready_o, 1);
    @(negedge clk_i);

    // Table vectors: push, hold, pop, push+pop at count 1, flush, latency.
    for (int i = 0; i < 11; i++) begin
      inst_valid_i = tbl[i].v; inst_i = tbl[i].d;
      inst_ready_i = tbl[i].rdy; flush_i = tbl[i].fl;
      #1;
      check($sformatf("vec%0d count", i), count_o, tbl[i].e_cnt);
      check($sformatf("vec%0d valid", i), inst_valid_o, tbl[i].e_val);
      check($sformatf("vec%0d empty", i), empty_o, tbl[i].e_cnt == 0);
      check($sformatf("vec%0d ready", i), inst_ready_o, tbl[i].e_rdy);
      if (tbl[i].e_val) check($sformatf("vec%0d head", i), inst_o, tbl[i].e_head);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    model.delete();

    // Fill and drain.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, "fd rst");
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(20 + i), 1'b0, 1'b0, 1'b0, "fd fill");
    #1;
    check("fd full",  full_o, 1);
    check("fd ready", inst_ready_o, 0);
    check("fd count", count_o, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("fd order", inst_o, mk(20 + i));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, "fd drain");
    end
    check("fd empty", empty_o, 1);

    // Streaming: push and pop every cycle through two pointer wraps.
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        #1;
        check("st count1", count_o, 1);
        check("st order", inst_o, mk(40 + i - 1));
      end
      step(1'b1, mk(40 + i), 1'b1, 1'b0, 1'b0, "st");
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "st tail");
    check("st empty", empty_o, 1);

    // Backpressure: three entries, consumer ready toggling 1,0,1,0,...
    for (int i = 0; i < 3; i++) step(1'b1, mk(70 + i), 1'b0, 1'b0, 1'b0, "bp fill");
    pops = 0; have_held = 1'b0; held = '0;
    for (int k = 0; k < 8; k++) begin
      inst_valid_i = 1'b0; inst_ready_i = (k % 2 == 0); flush_i = 1'b0;
      #1;
      if (have_held) check("bp hold", inst_o, held);
      have_held = inst_valid_o && !inst_ready_i;
      held = inst_o;
      if (inst_valid_o && inst_ready_i) begin
        check("bp order", inst_o, mk(70 + pops));
        pops++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("bp pops", pops, 3);
    check("bp empty", empty_o, 1);
    model.delete();

    // Flush with simultaneous push and pop attempts at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, mk(90 + i), 1'b0, 1'b0, 1'b0, "fl fill");
    step(1'b1, mk(99), 1'b1, 1'b1, 1'b0, "fl flush");
    check("fl count", count_o, 0);
    check("fl valid", inst_valid_o, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, "fl idle");
    step(1'b1, mk(100), 1'b0, 1'b0, 1'b0, "fl push");
    check("fl new head", inst_o, mk(100));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "fl pop");

    // Full boundary: push refused while a pop happens.
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(110 + i), 1'b0, 1'b0, 1'b0, "fb fill");
    step(1'b1, mk(127), 1'b1, 1'b0, 1'b0, "fb pushpop");
    check("fb count", count_o, DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, "fb drain");

    // Reset mid-run at count 4, then one-cycle push latency.
    for (int i = 0; i < 4; i++) step(1'b1, mk(130 + i), 1'b0, 1'b0, 1'b0, "rm fill");
    step(1'b1, mk(139), 1'b1, 1'b0, 1'b1, "rm reset");
    check("rm count", count_o, 0);
    check("rm empty", empty_o, 1);
    step(1'b1, mk(140), 1'b0, 1'b0, 1'b0, "rm push");
    check("rm visible", inst_valid_o, 1);
    check("rm head", inst_o, mk(140));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, "rm pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of instruction entries; power of two, >= 2.
REQ-002 SHALL have port clk_i  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port inst_i  input  instruction_t: instruction from host.
REQ-005 SHALL have port inst_valid_i  input  1: host offers inst_i.
REQ-006 SHALL have port inst_ready_o  output  1: queue accepts inst_i this cycle.
REQ-007 SHALL have port flush_i  input  1: discard all stored entries.
REQ-008 SHALL have port inst_o  output  instruction_t: head entry, toward control stage.
REQ-009 SHALL have port inst_valid_o  output  1: inst_o holds a valid entry.
REQ-010 SHALL have port inst_ready_i  input  1: control stage consumes inst_o (control's inst_ready_o).
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 SHALL have port full_o  output  1: count_o == DEPTH.
REQ-013 SHALL have port empty_o  output  1: count_o == 0.

Function
REQ-014 Push SHALL occur when inst_valid_i && inst_ready_o; pop SHALL occur when inst_valid_o && inst_ready_i.
REQ-015 inst_ready_o SHALL equal !full_o && !flush_i, combinationally; it SHALL NOT depend on inst_ready_i, so there is no pass-through when full.
REQ-016 inst_valid_o SHALL equal !empty_o; inst_o SHALL be driven from the head storage entry.
REQ-017 Push-to-visible latency SHALL be 1 cycle: an entry pushed in cycle N appears on inst_o no earlier than cycle N+1, including when the queue is empty.
REQ-018 Entries SHALL leave in strict FIFO order; no entry SHALL be duplicated or lost.
REQ-019 inst_o SHALL hold stable while inst_valid_o && !inst_ready_i.
REQ-020 Occupancy update per cycle SHALL be: push only +1; pop only -1; push and pop together unchanged.
REQ-021 When count_o == 1, a simultaneous push and pop SHALL be legal; the new entry becomes head on the next cycle.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-023 flush_i SHALL, at the next edge, set count to 0 and both pointers to 0.
REQ-024 A pop in a flush_i cycle SHALL be ignored (no double decrement); no push SHALL be accepted in a flush_i cycle.
REQ-025 Storage contents SHALL NOT require clearing on flush or reset; only pointers and count are reset.
REQ-026 When not full, an inst_valid_i deasserted without a handshake SHALL change no state.

Reset
REQ-027 While rst_i is high at a clock edge: write pointer = 0, read pointer = 0, count = 0.
REQ-028 After reset: inst_valid_o = 0, empty_o = 1, full_o = 0, count_o = 0, inst_ready_o = 1 (when flush_i = 0).
REQ-029 Reset asserted mid-operation SHALL discard all entries, with the same result as REQ-027.
REQ-030 rst_i SHALL take priority over flush_i, push and pop.

Structure
REQ-031 instruction_t SHALL come from common_pkg; a constant INST_Q_DEPTH (default 8) SHALL be added to common_pkg and used at instantiation.
REQ-032 Storage SHALL be one sub-module, inst_queue_ram: DEPTH x instruction_t, one synchronous write port, asynchronous read at the read pointer.
REQ-033 Pointer and count registers SHALL use the shared reset flip-flop macros.
REQ-034 inst_queue SHALL instantiate directly upstream of control: inst_o -> inst_i, inst_valid_o -> inst_valid_i, inst_ready_i <- inst_ready_o.

Verification
REQ-035 Fill and drain: reset, push 8 distinct instructions with inst_ready_i = 0 -> full_o = 1, inst_ready_o = 0, count_o = 8; then set inst_ready_i = 1 -> the 8 entries leave in order, and empty_o = 1 after 8 pops.
REQ-036 Streaming: push and pop every cycle, 20 entries through DEPTH = 8 -> count_o stays 1 after the first cycle, order is preserved, and pointers wrap twice with no bubble.
REQ-037 Backpressure: 3 entries queued, inst_ready_i toggled 1010... -> inst_o is stable whenever inst_ready_i = 0, and exactly 3 pops occur.
REQ-038 Flush: count_o = 5, then flush_i with a simultaneous push and pop attempt -> the next cycle has count_o = 0, inst_valid_o = 0, and neither the pushed entry nor any old entry appears.
REQ-039 Full boundary: count_o = 8 with a push and a pop in the same cycle -> the push is refused (inst_ready_o = 0) and count_o = 7.
REQ-040 Reset mid-run: count_o = 4, rst_i for 1 cycle -> count_o = 0, empty_o = 1; the next push appears on inst_o 1 cycle later.
